// File: rtl/tinker_regfile_scoreboard.sv
// rtl/tinker_regfile_scoreboard.sv - register file with writeback bypass and pending-write scoreboard
module tinker_regfile_scoreboard #(
    parameter int XLEN         = 64,
    parameter int NREG         = 32,
    parameter int NRD          = 3,
    parameter int SP_IDX       = 31,
    parameter int SP_INIT      = 524288,
    parameter int MAX_INFLIGHT = 4,
    localparam int AW          = $clog2(NREG),
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_accept,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                cancel_valid,
    input  logic [AW-1:0]       cancel_rd,
    output logic [XLEN-1:0]     sp_out,
    output logic                sb_err
);

    logic [XLEN-1:0] regs    [NREG];
    logic [CW-1:0]   cnt     [NREG];
    logic [CW-1:0]   cnt_nxt [NREG];
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dw_vec;
    logic [NREG-1:0] dc_vec;
    logic            err_any;

    always_comb begin
        dw_vec = '0;
        dc_vec = '0;
        if (wb_valid)
            dw_vec[wb_addr] = 1'b1;
        if (cancel_valid)
            dc_vec[cancel_rd] = 1'b1;
    end

    // A release in the same cycle frees a slot, so a full counter can still accept.
    assign issue_accept = !(cnt[issue_rd] == CW'(MAX_INFLIGHT) &&
                            !dw_vec[issue_rd] && !dc_vec[issue_rd]);

    always_comb begin
        inc_vec = '0;
        if (issue_valid && issue_accept)
            inc_vec[issue_rd] = 1'b1;
    end

    always_comb begin
        logic [CW+1:0] sum;
        sum     = '0;
        err_any = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            sum = {2'b00, cnt[r]}
                + {{(CW+1){1'b0}}, inc_vec[r]}
                - {{(CW+1){1'b0}}, dw_vec[r]}
                - {{(CW+1){1'b0}}, dc_vec[r]};
            cnt_nxt[r] = sum[CW+1] ? '0 : sum[CW-1:0];
            if (cnt[r] == '0 && (dw_vec[r] || dc_vec[r]))
                err_any = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= (r == SP_IDX) ? XLEN'(SP_INIT) : '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
            if (wb_valid)
                regs[wb_addr] <= wb_data;
            if (err_any)
                sb_err <= 1'b1;
        end
    end

    // Readiness subtracts same-cycle releases but ignores a same-cycle issue.
    always_comb begin
        logic [AW-1:0] a;
        logic [CW+1:0] diff;
        a        = '0;
        diff     = '0;
        rd_data  = '0;
        rd_ready = '0;
        for (int i = 0; i < NRD; i++) begin
            a    = rd_addr[i*AW +: AW];
            diff = {2'b00, cnt[a]}
                 - {{(CW+1){1'b0}}, dw_vec[a]}
                 - {{(CW+1){1'b0}}, dc_vec[a]};
            rd_ready[i]             = (diff == '0);
            rd_data[i*XLEN +: XLEN] = (wb_valid && wb_addr == a) ? wb_data : regs[a];
        end
    end

    assign sp_out = regs[SP_IDX];

endmodule
